serial_add_sub: RTL and testbench
=================================

# serial_add_sub

Multi-cycle, parametrised adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock. It uses a registered carry between digits. It is the next generation of the team's single-bit ripple adder cell: generalised width, add/subtract mode, status flags and a start/done handshake. It sits beside the ALU and serves area-constrained datapaths that can tolerate WIDTH/DIGIT cycles of latency.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  sum/difference modulo 2^WIDTH.
- cOut  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.

## Operation
- N = WIDTH/DIGIT digit steps per operation. Digits are processed LSB first.
- States:
  - IDLE: after reset.
  - RUN: digit steps in progress.
  - DONE: lasts one cycle, with done=1.
  - DONE returns to IDLE unless start is high, in which case it goes directly to RUN.
- Accept (IDLE or DONE, start=1):
  - latch A into the operand register.
  - latch B XOR {WIDTH{sub}} into the second operand register.
  - carry register ← sub.
  - digit counter ← 0; go to RUN.
- Each RUN cycle:
  - add the low DIGIT bits of both operand registers plus carry.
  - shift the DIGIT sum bits into the top of the result shift register.
  - shift both operand registers right by DIGIT.
  - carry ← digit carry-out; counter++.
- On the step with counter = N−1:
  - capture cOut = carry out of the MSB.
  - capture overflow = carry into the MSB XOR carry out of the MSB.
  - go to DONE.
- zero is combinational on the final result register.
- result, cOut, overflow and zero hold their values until the next accepted start. They are not cleared in IDLE.
- start while busy is ignored entirely: no latch, no restart.
- reset (any state, including mid-RUN):
  - state ← IDLE; counter ← 0; carry ← 0.
  - busy=0, done=0, result=0, cOut=0, overflow=0.
  - zero=1, since result=0.
- DIGIT = WIDTH is legal: N = 1, so the operation is one RUN cycle followed by DONE.

## Timing
- Start accepted at edge E0. RUN covers the cycles after edges E0 … E(N−1). done=1 in the cycle following edge EN.
- Latency from start-sampling edge to done visible: N cycles. For 32/4 that is 8 cycles.
- busy is high for exactly N cycles per operation.
- Throughput: one operation per N+1 cycles. Start held high continuously re-accepts in the DONE cycle, giving back-to-back operations.
- Reset values: all outputs as listed under reset above.

## Structure
- Shared package alu_pkg holds:
  - state encoding constants: IDLE, RUN, DONE.
  - opcode constants OP_ADD = 0 and OP_SUB = 1.
- One sub-module, add_ndigit #(DIGIT): a combinational DIGIT-bit ripple adder built from full-adder cells.
  - Outputs: sum, carry-out, and carry into its top bit. The carry into the top bit is needed for overflow.
  - Instantiated once; the top level holds the FSM, counter, shift registers and flag registers.

## Test plan
- WIDTH=32, DIGIT=4, add 5 + 3 → result 0x00000008, cOut=0, overflow=0, zero=0. done exactly 8 cycles after the start edge; busy high for 8 cycles.
- Add 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, cOut=0. Add 0xFFFFFFFF + 0x00000001 → result 0, cOut=1, overflow=0, zero=1.
- Sub 3 − 5 → result 0xFFFFFFFE, cOut=0 (borrow), overflow=0. Sub 0x80000000 − 1 → result 0x7FFFFFFF, overflow=1, cOut=1.
- Pulse start with A=1, B=1 at the cycle-3 mark of an in-flight 10+20 operation → result 30. The second start is ignored; only one done pulse occurs.
- Assert reset in RUN cycle 4 → next cycle busy=0, done=0, result=0, zero=1. A fresh start of 7+8 then completes normally with result 15.
- Parameter sweep: DIGIT=1, 8 and 32 with WIDTH=32, random operands in both modes against a reference model. Check latency N = 32, 4 and 1 respectively. Check back-to-back operations with start held high.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the serial adder/subtractor: FSM state encoding and opcodes.
package alu_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_ndigit.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Also exports the carry into the top bit so the caller can form signed overflow.
module add_ndigit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             ctop
);

    logic [DIGIT:0] c;
    genvar gi;

    assign c[0] = cin;

    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[DIGIT];
    assign ctop = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// LSB first, with a registered carry between digits and a start/done handshake.
module serial_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cOut,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [DIGIT-1:0] sum_next;
    logic             dcout_next;
    logic             dctop_next;
    logic [WIDTH-1:0] res_next;

    add_ndigit #(.DIGIT(DIGIT)) u_add (
        .a    (a_reg[DIGIT-1:0]),
        .b    (b_reg[DIGIT-1:0]),
        .cin  (carry_reg),
        .sum  (sum_next),
        .cout (dcout_next),
        .ctop (dctop_next)
    );

    // New digit enters at the top; after N steps the first digit has reached bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign res_next = sum_next;
        end else begin : g_part
            assign res_next = {sum_next, res_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    res_reg   <= res_next;
                    carry_reg <= dcout_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_reg <= DONE;
                        cout_reg  <= dcout_next;
                        ovf_reg   <= dctop_next ^ dcout_next;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; subtract is A + ~B + 1.
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B ^ {WIDTH{sub}};
                        carry_reg <= (sub == OP_SUB);
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign result   = res_reg;
    assign cOut     = cout_reg;
    assign overflow = ovf_reg;
    assign zero     = (res_reg == '0);

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed checks on a 32/4 instance plus a DIGIT sweep (1, 8, 32)
// with back-to-back random operations; expected results come from an arithmetic reference model.
module tb_serial_add_sub;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cOut;
    logic        overflow;
    logic        zero;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(32), .DIGIT(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cOut     (cOut),
        .overflow (overflow),
        .zero     (zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] t;
        t     = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.res = t[31:0];
        // For subtract the carry flag is "no borrow", i.e. a >= b unsigned.
        e.c   = s ? (a >= b) : t[32];
        e.v   = s ? ((a[31] != b[31]) && (e.res[31] != a[31]))
                  : ((a[31] == b[31]) && (e.res[31] != a[31]));
        return e;
    endfunction

    // Scoreboard pop on every done pulse of the main instance.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            $display("main done result=%h cout=%b ovf=%b zero=%b", result, cOut, overflow, zero);
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("cout", 64'(cOut), 64'(e.c));
                chk("overflow", 64'(overflow), 64'(e.v));
                chk("zero", 64'(zero), 64'(e.res == 32'd0));
            end
        end
    end

    task automatic wait_done(output int lat, output int busyc);
        lat   = 0;
        busyc = 0;
        while (!done && lat < 200) begin
            if (busy) busyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int busyc;
        start = 1'b1; sub = s; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        sb.push_back(ref_model(s, a, b));
        wait_done(lat, busyc);
        chk("latency", 64'(lat), 64'd8);
        chk("busy_cycles", 64'(busyc), 64'd8);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    // DIGIT sweep: each instance runs start-held-high back-to-back random operations.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sw
            localparam int DG = (gi == 0) ? 1 : ((gi == 1) ? 8 : 32);
            localparam int NS = 32 / DG;
            logic        rst, st, s, bsy, dn, co, ov, zr;
            logic [31:0] a, b, res;
            exp_t        q[$];
            bit          fin = 1'b0;

            serial_add_sub #(.WIDTH(32), .DIGIT(DG)) u_sw (
                .clk      (clk),
                .reset    (rst),
                .start    (st),
                .sub      (s),
                .A        (a),
                .B        (b),
                .busy     (bsy),
                .done     (dn),
                .result   (res),
                .cOut     (co),
                .overflow (ov),
                .zero     (zr)
            );

            initial begin
                int   lat;
                exp_t e;
                rst = 1'b1; st = 1'b0; s = 1'b0; a = '0; b = '0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                st = 1'b1; s = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
                for (int k = 0; k < 8; k++) begin
                    @(posedge clk); #1;
                    q.push_back(ref_model(s, a, b));
                    if (k == 7) st = 1'b0;
                    s = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
                    if (k == 2) a = 32'h8000_0000;
                    if (k == 3) b = a;
                    lat = 0;
                    while (!dn && lat < 100) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    chk("sw_latency", 64'(lat), 64'(NS));
                    if (q.size() == 0) begin
                        chk("sw_sb_empty", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        $display("sweep digit=%0d result=%h cout=%b ovf=%b", DG, res, co, ov);
                        chk("sw_result", 64'(res), 64'(e.res));
                        chk("sw_cout", 64'(co), 64'(e.c));
                        chk("sw_overflow", 64'(ov), 64'(e.v));
                        chk("sw_zero", 64'(zr), 64'(e.res == 32'd0));
                    end
                end
                fin = 1'b1;
            end
        end
    endgenerate

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        int busyc;
        int d0;
        reset = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout", 64'(cOut), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);

        run_op(1'b0, 32'd5, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_result", 64'(result), 64'd8);
        chk("hold_zero", 64'(zero), 64'd0);

        run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(1'b1, 32'd3, 32'd5);
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001);

        // Reset in the fourth RUN cycle; flags from the previous op are still set.
        start = 1'b1; sub = 1'b0; A = 32'd100; B = 32'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_zero", 64'(zero), 64'd1);
        chk("midrst_cout", 64'(cOut), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        run_op(1'b0, 32'd7, 32'd8);

        // Start pulsed while busy must be ignored.
        d0 = done_cnt;
        start = 1'b1; sub = 1'b0; A = 32'd10; B = 32'd20;
        @(posedge clk); #1;
        start = 1'b0;
        sb.push_back(ref_model(1'b0, 32'd10, 32'd20));
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; A = 32'd1; B = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, busyc);
        chk("busy_start_result", 64'(result), 64'd30);
        repeat (12) @(posedge clk);
        #1;
        chk("busy_start_done_count", 64'(done_cnt - d0), 64'd1);

        lat = 0;
        while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && lat < 5000) begin
            @(posedge clk);
            lat++;
        end
        if (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin)) chk("sweep_timeout", 64'd0, 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
